delay_unit_driver: RTL and testbench
====================================

Name: delay_unit_driver

Overview:
- Two-lane ready/valid transmitter and return-checker for the delay-unit stream interface. It is the producer and consumer end of that interface.
- Each lane issues a programmed number of beats with incrementing data into the DUT's INPUT_n channels. It accepts the DUT's OUTPUT_n beats and checks data order and return latency.
- Lane crossing is configurable. Used as an in-fabric traffic source/sink for delay-unit bring-up and formal harnesses.

Parameters:
- WIDTH, 5, data width per lane.
- MAX_OUT, 4, max outstanding (sent, not yet returned) beats per lane; power of two, ≥2.
- TIMEOUT, 8, max cycles with outstanding > 0 and no return beat on that lane before error.
- SWAP, 1: return lane for send lane i is 1-i. 0: return lane is i.

Ports:
- CLK  in  1  clock, all state on posedge
- RESETN  in  1  synchronous active-low reset, sampled on posedge CLK
- start  in  1  one-cycle pulse; accepted only in IDLE
- count  in  8  beats per lane for this run; latched on start; 0 = immediate DONE
- seed_0, seed_1  in  WIDTH  first data value per lane; latched on start
- TX_0_data, TX_1_data  out  WIDTH  send data, drives DUT INPUT_n_data
- TX_0_valid, TX_1_valid  out  1  send valid
- TX_0_ready, TX_1_ready  in  1  DUT INPUT_n_ready
- RX_0_data, RX_1_data  in  WIDTH  DUT OUTPUT_n_data
- RX_0_valid, RX_1_valid  in  1  DUT OUTPUT_n_valid
- RX_0_ready, RX_1_ready  out  1  drives DUT OUTPUT_n_ready
- busy  out  1  high in SEND or DRAIN
- done  out  1  one-cycle pulse on entry to IDLE from DRAIN
- error  out  1  sticky; cleared by start or reset
- err_count  out  8  saturating mismatch/timeout/overflow count; cleared on start

Behaviour:
- Reset (RESETN=0 at posedge): state IDLE. All TX_*_valid, RX_*_ready, busy, done, error = 0. err_count = 0. All counters 0. Reset overrides start and any in-flight beat; a partial beat is dropped without a handshake.
- Top FSM has four states.
  - IDLE: on start, latch count and seeds, clear error and err_count, go to SEND. If count==0, go directly to DONE.
  - SEND: per lane, issue beats until sent_i==count. When both lanes are finished sending, go to DRAIN.
  - DRAIN: wait for all returns. When outstanding_0==outstanding_1==0 and both rcvd==count, go to DONE.
  - DONE: one cycle with done=1, then IDLE.
- Send rule per lane i:
  - TX_i_valid = (SEND) && sent_i<count && out_i<MAX_OUT.
  - TX_i_data = seed_i + sent_i, mod 2^WIDTH (wraps 31→0 at WIDTH=5).
  - A beat transfers when valid && ready at posedge; then sent_i++ and out_i++.
  - Once valid is asserted, data and valid hold until the handshake. A stall at out_i==MAX_OUT only blocks new assertion, never deasserts a pending beat. Evaluate the cap before asserting.
- Return rule:
  - RX_j_ready = 1 in SEND and DRAIN, else 0.
  - Return lane j maps to send lane i via SWAP.
  - On RX_j handshake, compare RX_j_data with exp_i = seed_i + rcvd_i, mod 2^WIDTH. Then rcvd_i++ and out_i--, and the lane's timer reloads to 0.
  - A mismatch sets error and increments err_count; the beat still counts.
- Simultaneous send and return on the same lane in one cycle: out_i unchanged.
- A return with out_i==0 is overflow: error, err_count++, out_i stays 0, rcvd unchanged.
- Timeout:
  - timer_i increments each cycle while out_i>0 with no return on lane i.
  - When timer_i reaches TIMEOUT: error, err_count++, timer_i reloads to 0. The FSM stays in DRAIN; only reset or a new run exits.
- err_count saturates at 255.
- start outside IDLE is ignored.
- busy = (state==SEND || state==DRAIN).

Decomposition:
- Package delay_unit_pkg holds:
  - FSM state enum: IDLE, SEND, DRAIN, DONE.
  - Default WIDTH/MAX_OUT/TIMEOUT constants.
  - Lane index type.
  - Error-cause enum: MISMATCH, TIMEOUT, OVERFLOW. Exported for bench scoreboard use.
- One sub-module: delay_unit_driver_lane. It holds per-lane sent/rcvd/outstanding/timer counters, TX valid/data generation and expected-data compare. It is instantiated twice.
- The top keeps the FSM, SWAP routing, and error/err_count aggregation.

Test Plan:
- Loopback, SWAP=1, DUT returns after 3 cycles, always ready. count=4, seed_0=3, seed_1=30. Lane 0 sends 3,4,5,6. Lane 1 sends 30,31,0,1 (wrap). Returns match. done pulses once. error=0, err_count=0.
- Backpressure: TX_0_ready low for 5 cycles mid-beat. TX_0_valid and TX_0_data stay held constant until ready rises. No duplicate or dropped beat; sent_0 ends at count.
- Outstanding cap: DUT never returns, count=8. Exactly MAX_OUT=4 beats transfer per lane, then valid stays low. After TIMEOUT=8 idle cycles, error=1 and err_count=2 (one per lane).
- Corrupt return: DUT flips bit 0 of the second beat on RX_1 (lane 0, seed 0, expects 1, sees 0). error=1, err_count=1, run still completes with done.
- Overflow: RX_0_valid pulses while out_1==0. error=1 and err_count increments; outstanding does not underflow.
- Reset mid-SEND: RESETN low for 1 cycle after 2 beats. Next cycle all valids, readies and busy are 0, state is IDLE. A following start with count=2 runs cleanly.

Source files
------------

// File: rtl/delay_unit_driver_pkg.sv
// Shared types and defaults for the delay-unit traffic driver and its bench.
package delay_unit_pkg;

    localparam int DEF_WIDTH   = 5;
    localparam int DEF_MAX_OUT = 4;
    localparam int DEF_TIMEOUT = 8;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    typedef logic lane_t;

    typedef enum logic [1:0] {ERR_MISMATCH, ERR_TIMEOUT, ERR_OVERFLOW} err_cause_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/delay_unit_driver_if.sv
// Two-lane ready/valid stream bundle between the driver (master) and the delay unit (slave).
interface delay_unit_driver_if #(parameter int WIDTH = 5);
    logic [WIDTH-1:0] TX_0_data, TX_1_data;
    logic             TX_0_valid, TX_1_valid;
    logic             TX_0_ready, TX_1_ready;
    logic [WIDTH-1:0] RX_0_data, RX_1_data;
    logic             RX_0_valid, RX_1_valid;
    logic             RX_0_ready, RX_1_ready;

    modport master (
        output TX_0_data, TX_1_data, TX_0_valid, TX_1_valid, RX_0_ready, RX_1_ready,
        input  TX_0_ready, TX_1_ready, RX_0_data, RX_1_data, RX_0_valid, RX_1_valid
    );

    modport slave (
        input  TX_0_data, TX_1_data, TX_0_valid, TX_1_valid, RX_0_ready, RX_1_ready,
        output TX_0_ready, TX_1_ready, RX_0_data, RX_1_data, RX_0_valid, RX_1_valid
    );
endinterface

// File: rtl/delay_unit_driver_lane.sv
// One lane: issues seed-based incrementing beats, capped at MAX_OUT outstanding, and
// checks returned beats for order and latency. TX valid/data are combinational from state.
module delay_unit_driver_lane
    import delay_unit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             load,
    input  logic [7:0]       count,
    input  logic [WIDTH-1:0] seed,
    input  logic             send_en,
    input  logic             active,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    input  logic             rx_fire,
    input  logic [WIDTH-1:0] rx_data,
    output logic             send_done,
    output logic             drained,
    output logic             err_mismatch,
    output logic             err_overflow,
    output logic             err_timeout
);
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [7:0]       cnt_q, sent_q, rcvd_q;
    logic [WIDTH-1:0] seed_q;
    logic [OW-1:0]    out_q;
    logic [TW-1:0]    timer_q;
    logic             tx_fire, ret_ok;

    // valid only depends on counters that a handshake advances, so a pending beat never drops
    assign tx_valid  = send_en && (sent_q < cnt_q) && (out_q < OW'(MAX_OUT));
    assign tx_data   = seed_q + WIDTH'(sent_q);
    assign tx_fire   = tx_valid && tx_ready;
    assign ret_ok    = rx_fire && (out_q != '0);

    assign err_overflow = rx_fire && (out_q == '0);
    assign err_mismatch = ret_ok && (rx_data != seed_q + WIDTH'(rcvd_q));
    assign err_timeout  = active && (out_q != '0) && !rx_fire && (timer_q == TW'(TIMEOUT - 1));
    assign send_done    = (sent_q == cnt_q);
    assign drained      = (out_q == '0) && (rcvd_q == cnt_q);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt_q   <= '0;
            seed_q  <= '0;
            sent_q  <= '0;
            rcvd_q  <= '0;
            out_q   <= '0;
            timer_q <= '0;
        end else if (load) begin
            cnt_q   <= count;
            seed_q  <= seed;
            sent_q  <= '0;
            rcvd_q  <= '0;
            out_q   <= '0;
            timer_q <= '0;
        end else begin
            if (tx_fire) sent_q <= sent_q + 8'd1;
            if (ret_ok)  rcvd_q <= rcvd_q + 8'd1;
            if (tx_fire && !ret_ok)
                out_q <= out_q + OW'(1);
            else if (!tx_fire && ret_ok)
                out_q <= out_q - OW'(1);
            if (rx_fire || (out_q == '0) || err_timeout)
                timer_q <= '0;
            else if (active)
                timer_q <= timer_q + TW'(1);
        end
    end
endmodule

// File: rtl/delay_unit_driver.sv
// Two-lane delay-unit traffic source/sink: run FSM, return-lane routing, error aggregation.
// Sends stall per lane on TX ready or the outstanding cap; returns are always accepted while busy.
module delay_unit_driver
    import delay_unit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter bit SWAP    = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 start,
    input  logic [7:0]           count,
    input  logic [WIDTH-1:0]     seed_0,
    input  logic [WIDTH-1:0]     seed_1,
    delay_unit_driver_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           err_count
);
    state_t           state, state_nxt;
    logic             load, send_en;
    logic             rx0_fire, rx1_fire, l0_fire, l1_fire;
    logic [WIDTH-1:0] l0_data, l1_data;
    logic             l0_send_done, l1_send_done, l0_drained, l1_drained;
    logic             l0_mis, l0_ovf, l0_to, l1_mis, l1_ovf, l1_to;
    logic [1:0]       n_err;

    assign send_en = (state == SEND);
    assign busy    = (state == SEND) || (state == DRAIN);
    assign done    = (state == DONE);

    assign bus.RX_0_ready = busy;
    assign bus.RX_1_ready = busy;
    assign rx0_fire = bus.RX_0_valid && bus.RX_0_ready;
    assign rx1_fire = bus.RX_1_valid && bus.RX_1_ready;

    // with SWAP, send lane i comes back on return lane 1-i
    assign l0_fire = SWAP ? rx1_fire : rx0_fire;
    assign l0_data = SWAP ? bus.RX_1_data : bus.RX_0_data;
    assign l1_fire = SWAP ? rx0_fire : rx1_fire;
    assign l1_data = SWAP ? bus.RX_0_data : bus.RX_1_data;

    delay_unit_driver_lane #(.WIDTH(WIDTH), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) u_lane0 (
        .CLK(CLK), .RESETN(RESETN), .load(load), .count(count), .seed(seed_0),
        .send_en(send_en), .active(busy),
        .tx_valid(bus.TX_0_valid), .tx_data(bus.TX_0_data), .tx_ready(bus.TX_0_ready),
        .rx_fire(l0_fire), .rx_data(l0_data),
        .send_done(l0_send_done), .drained(l0_drained),
        .err_mismatch(l0_mis), .err_overflow(l0_ovf), .err_timeout(l0_to)
    );

    delay_unit_driver_lane #(.WIDTH(WIDTH), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) u_lane1 (
        .CLK(CLK), .RESETN(RESETN), .load(load), .count(count), .seed(seed_1),
        .send_en(send_en), .active(busy),
        .tx_valid(bus.TX_1_valid), .tx_data(bus.TX_1_data), .tx_ready(bus.TX_1_ready),
        .rx_fire(l1_fire), .rx_data(l1_data),
        .send_done(l1_send_done), .drained(l1_drained),
        .err_mismatch(l1_mis), .err_overflow(l1_ovf), .err_timeout(l1_to)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (count == 8'd0) ? DONE : SEND;
                end
            end
            SEND:    if (l0_send_done && l1_send_done) state_nxt = DRAIN;
            DRAIN:   if (l0_drained && l1_drained)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // each lane raises at most one error cause per cycle
    assign n_err = 2'(l0_mis | l0_ovf | l0_to) + 2'(l1_mis | l1_ovf | l1_to);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            error     <= 1'b0;
            err_count <= 8'd0;
        end else if (load) begin
            error     <= 1'b0;
            err_count <= 8'd0;
        end else if (n_err != 2'd0) begin
            error     <= 1'b1;
            err_count <= sat_add8(err_count, n_err);
        end
    end
endmodule

// File: tb/tb_delay_unit_driver.sv
// Directed bench: 3-cycle loopback model with lane swap, TX beats scored against expected queues.
module tb_delay_unit_driver;
    import delay_unit_pkg::*;

    localparam int W = DEF_WIDTH;

    typedef struct {
        logic [W-1:0] data;
        int           t;
    } ret_t;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   count = 8'd0;
    logic [W-1:0] seed_0 = '0, seed_1 = '0;
    logic         busy, done, error;
    logic [7:0]   err_count;

    delay_unit_driver_if #(.WIDTH(W)) bus();

    delay_unit_driver #(.WIDTH(W), .MAX_OUT(DEF_MAX_OUT), .TIMEOUT(DEF_TIMEOUT), .SWAP(1'b1)) dut (
        .CLK(CLK), .RESETN(RESETN), .start(start), .count(count),
        .seed_0(seed_0), .seed_1(seed_1), .bus(bus),
        .busy(busy), .done(done), .error(error), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    ret_t         pipe0[$], pipe1[$];
    logic [W-1:0] exp0[$], exp1[$];
    int           cyc, s0, s1, p1_pushed, n_assert, n_fail, nd;
    bit           ret_en, corrupt, force_rx0;
    err_cause_t   cause;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive_rx();
        bus.RX_0_valid = force_rx0 || (pipe0.size() > 0 && pipe0[0].t <= cyc);
        bus.RX_0_data  = force_rx0 ? W'(17) : (pipe0.size() > 0 ? pipe0[0].data : '0);
        bus.RX_1_valid = (pipe1.size() > 0 && pipe1[0].t <= cyc);
        bus.RX_1_data  = (pipe1.size() > 0) ? pipe1[0].data : '0;
    endtask

    // evaluate the handshakes of the coming posedge, then advance one clock
    task automatic cycle();
        ret_t r;
        if (RESETN) begin
            if (bus.TX_0_valid && bus.TX_0_ready) begin
                s0++;
                check("tx0_expected", 32'(exp0.size() > 0), 1);
                if (exp0.size() > 0) check("tx0_data", 32'(bus.TX_0_data), 32'(exp0.pop_front()));
                if (ret_en) begin
                    r.data = bus.TX_0_data;
                    if (corrupt && p1_pushed == 1) r.data[0] = ~r.data[0];
                    r.t = cyc + 3;
                    pipe1.push_back(r);
                    p1_pushed++;
                end
            end
            if (bus.TX_1_valid && bus.TX_1_ready) begin
                s1++;
                check("tx1_expected", 32'(exp1.size() > 0), 1);
                if (exp1.size() > 0) check("tx1_data", 32'(bus.TX_1_data), 32'(exp1.pop_front()));
                if (ret_en) begin
                    r.data = bus.TX_1_data;
                    r.t = cyc + 3;
                    pipe0.push_back(r);
                end
            end
            if (bus.RX_0_valid && bus.RX_0_ready && !force_rx0 && pipe0.size() > 0) pipe0.delete(0);
            if (bus.RX_1_valid && bus.RX_1_ready && pipe1.size() > 0) pipe1.delete(0);
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        drive_rx();
    endtask

    task automatic do_start(input logic [7:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] v;
        exp0.delete(); exp1.delete(); pipe0.delete(); pipe1.delete();
        s0 = 0; s1 = 0; p1_pushed = 0;
        count = c; seed_0 = a; seed_1 = b;
        for (int k = 0; k < int'(c); k++) begin
            v = a + W'(k); exp0.push_back(v);
            v = b + W'(k); exp1.push_back(v);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_done(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget && n == 0; i++) begin
            cycle();
            if (done) n++;
        end
        repeat (3) begin
            cycle();
            if (done) n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0;
        ret_en = 1'b1; corrupt = 1'b0; force_rx0 = 1'b0;
        bus.TX_0_ready = 1'b1; bus.TX_1_ready = 1'b1;
        drive_rx();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;

        check("rst_tx0_valid", 32'(bus.TX_0_valid), 0);
        check("rst_tx1_valid", 32'(bus.TX_1_valid), 0);
        check("rst_rx0_ready", 32'(bus.RX_0_ready), 0);
        check("rst_rx1_ready", 32'(bus.RX_1_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_err_count", 32'(err_count), 0);

        // loopback with lane-1 data wrap
        do_start(8'd4, W'(3), W'(30));
        check("t1_busy", 32'(busy), 1);
        run_done(100, nd);
        check("t1_done_pulses", 32'(nd), 1);
        check("t1_error", 32'(error), 0);
        check("t1_err_count", 32'(err_count), 0);
        check("t1_exp0_left", 32'(exp0.size()), 0);
        check("t1_exp1_left", 32'(exp1.size()), 0);
        check("t1_busy_end", 32'(busy), 0);

        // backpressure on lane 0 after its first beat
        do_start(8'd4, W'(10), W'(20));
        for (int i = 0; i < 20 && s0 < 1; i++) cycle();
        bus.TX_0_ready = 1'b0;
        repeat (5) begin
            check("t2_hold_valid", 32'(bus.TX_0_valid), 1);
            check("t2_hold_data", 32'(bus.TX_0_data), 11);
            cycle();
        end
        bus.TX_0_ready = 1'b1;
        run_done(100, nd);
        check("t2_done_pulses", 32'(nd), 1);
        check("t2_sent0", 32'(s0), 4);
        check("t2_sent1", 32'(s1), 4);
        check("t2_error", 32'(error), 0);
        check("t2_exp0_left", 32'(exp0.size()), 0);

        // no returns: outstanding cap then timeout on both lanes
        ret_en = 1'b0;
        cause = ERR_TIMEOUT;
        do_start(8'd8, W'(0), W'(0));
        for (int i = 0; i < 40 && !error; i++) cycle();
        check({"t3_error_", cause.name()}, 32'(error), 1);
        check({"t3_err_count_", cause.name()}, 32'(err_count), 2);
        check("t3_sent0", 32'(s0), 4);
        check("t3_sent1", 32'(s1), 4);
        check("t3_tx0_valid", 32'(bus.TX_0_valid), 0);
        check("t3_tx1_valid", 32'(bus.TX_1_valid), 0);
        check("t3_busy", 32'(busy), 1);
        RESETN = 1'b0;
        cycle();
        RESETN = 1'b1;
        ret_en = 1'b1;

        // second lane-0 beat corrupted on RX_1
        cause = ERR_MISMATCH;
        corrupt = 1'b1;
        do_start(8'd4, W'(0), W'(7));
        run_done(100, nd);
        corrupt = 1'b0;
        check({"t4_done_", cause.name()}, 32'(nd), 1);
        check({"t4_error_", cause.name()}, 32'(error), 1);
        check({"t4_err_count_", cause.name()}, 32'(err_count), 1);

        // spurious RX_0 beat while lane 1 has nothing outstanding
        cause = ERR_OVERFLOW;
        bus.TX_0_ready = 1'b0;
        bus.TX_1_ready = 1'b0;
        do_start(8'd2, W'(5), W'(9));
        force_rx0 = 1'b1;
        drive_rx();
        cycle();
        force_rx0 = 1'b0;
        drive_rx();
        check({"t5_error_", cause.name()}, 32'(error), 1);
        check({"t5_err_count_", cause.name()}, 32'(err_count), 1);
        check("t5_tx1_valid", 32'(bus.TX_1_valid), 1);
        bus.TX_0_ready = 1'b1;
        bus.TX_1_ready = 1'b1;
        run_done(100, nd);
        check("t5_done_pulses", 32'(nd), 1);
        check("t5_err_count_end", 32'(err_count), 1);

        // reset in the middle of SEND, then a clean short run
        do_start(8'd4, W'(1), W'(2));
        for (int i = 0; i < 20 && s0 < 2; i++) cycle();
        RESETN = 1'b0;
        cycle();
        RESETN = 1'b1;
        check("t6_tx0_valid", 32'(bus.TX_0_valid), 0);
        check("t6_tx1_valid", 32'(bus.TX_1_valid), 0);
        check("t6_rx0_ready", 32'(bus.RX_0_ready), 0);
        check("t6_rx1_ready", 32'(bus.RX_1_ready), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_state_idle", 32'(dut.state == IDLE), 1);
        do_start(8'd2, W'(4), W'(6));
        run_done(100, nd);
        check("t6_done_pulses", 32'(nd), 1);
        check("t6_error", 32'(error), 0);
        check("t6_err_count", 32'(err_count), 0);
        check("t6_exp0_left", 32'(exp0.size()), 0);
        check("t6_exp1_left", 32'(exp1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
